// File: rtl/alu_op_scheduler_pkg.sv
// Shared definitions for the ALU operation scheduler.
//   state_t            : scheduler FSM states
//   ctrl_cmd fields    : bit positions inside the 8-bit ctrl_cmd
//   flag indices       : positions of N/Z/C/V inside the 4-bit flags word
//   cmd_updates_flags  : true when ctrl_cmd requests a flags write-back
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam int unsigned CLASS_HI = 7;
  localparam int unsigned CLASS_LO = 6;
  localparam int unsigned PASS_BIT = 5;
  localparam int unsigned OPC_HI   = 4;
  localparam int unsigned OPC_LO   = 1;
  localparam int unsigned S_BIT    = 0;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic cmd_updates_flags(input logic [7:0] cmd);
    return cmd[S_BIT];
  endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Bus bundle between the scheduler and its environment.
//   req_*      : per-requester request channel (valid/ready, packed operands)
//   alu_*      : registered operands to the shared ALU and its results back
//   rsp_*      : response channel (valid/ready)
//   flags_*    : external load of the architectural flags register
//   op_count   : completed-response counter
// Modports: master = environment (requesters, ALU, response sink),
//           slave  = scheduler.
interface alu_op_scheduler_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_src1;
  logic [NUM_REQ*32-1:0] req_src2;
  logic [NUM_REQ*8-1:0]  req_ctrl_cmd;

  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [7:0]  alu_ctrl_cmd;
  logic [3:0]  alu_current_flags;
  logic [31:0] alu_rd_out;
  logic [3:0]  alu_new_flags;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_data;
  logic [3:0]      rsp_flags;

  logic             flags_load;
  logic [3:0]       flags_in;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req_valid, req_src1, req_src2, req_ctrl_cmd,
    output alu_rd_out, alu_new_flags,
    output rsp_ready, flags_load, flags_in,
    input  req_ready, alu_src1, alu_src2, alu_ctrl_cmd, alu_current_flags,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags, op_count
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_ctrl_cmd,
    input  alu_rd_out, alu_new_flags,
    input  rsp_ready, flags_load, flags_in,
    output req_ready, alu_src1, alu_src2, alu_ctrl_cmd, alu_current_flags,
    output rsp_valid, rsp_id, rsp_data, rsp_flags, op_count
  );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   req         : request vector
//   rr_ptr      : highest-priority index for this arbitration
//   grant       : one-hot grant (zero when no request)
//   grant_idx   : index of the granted requester
//   grant_valid : some requester is granted
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan upward from rr_ptr with wrap; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      automatic int unsigned idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
// The winner's operands are latched into registers that drive the ALU; after
// ALU_LATENCY wait cycles the result and flags are captured and returned on
// the response channel. Owns the architectural flags register.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus            : alu_op_scheduler_if slave (request, ALU, response,
//                    flags load, op_count)
module alu_op_scheduler
  import alu_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ALU_LATENCY = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  alu_op_scheduler_if.slave  bus
);

  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WAIT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("alu_op_scheduler: NUM_REQ must be in 2..8");
  end

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       src1_q;
  logic [31:0]       src2_q;
  logic [7:0]        cmd_q;
  logic [3:0]        flags_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [3:0]        rsp_flags_q;
  logic [CNT_W-1:0]  op_count_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req         (bus.req_valid),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign bus.req_ready         = (state == IDLE) ? grant : '0;
  assign bus.alu_src1          = src1_q;
  assign bus.alu_src2          = src2_q;
  assign bus.alu_ctrl_cmd      = cmd_q;
  assign bus.alu_current_flags = flags_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_id            = id_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.rsp_flags         = rsp_flags_q;
  assign bus.op_count          = op_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      wait_cnt    <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      cmd_q       <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      op_count_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A flags load still applies when it coincides with an accept.
          if (bus.flags_load) begin
            flags_q <= bus.flags_in;
          end
          if (grant_valid) begin
            src1_q   <= bus.req_src1[grant_idx*32 +: 32];
            src2_q   <= bus.req_src2[grant_idx*32 +: 32];
            cmd_q    <= bus.req_ctrl_cmd[grant_idx*8 +: 8];
            id_q     <= grant_idx;
            wait_cnt <= WAIT_W'(ALU_LATENCY);
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            rsp_data_q  <= bus.alu_rd_out;
            rsp_flags_q <= bus.alu_new_flags;
            rsp_valid_q <= 1'b1;
            if (cmd_updates_flags(cmd_q)) begin
              flags_q <= bus.alu_new_flags;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 1'b1;
            rr_ptr      <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;

  logic clock;
  logic reset_n;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [3:0]  flags;
  } rsp_t;

  typedef struct {
    int unsigned id;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [7:0]  cmd;
    logic        fl;
    logic [3:0]  fin;
    logic [31:0] exp_data;
    logic [3:0]  exp_reg;
  } vec_t;

  rsp_t sb[$];

  alu_op_scheduler_if #(.NUM_REQ(2), .CNT_W(16)) if0 ();
  alu_op_scheduler_if #(.NUM_REQ(2), .CNT_W(16)) if1 ();

  alu_op_scheduler #(.NUM_REQ(2), .ALU_LATENCY(0), .CNT_W(16)) u_dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if0.slave)
  );

  alu_op_scheduler #(.NUM_REQ(2), .ALU_LATENCY(3), .CNT_W(16)) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if1.slave)
  );

  // ALU stub
  assign if0.alu_rd_out    = if0.alu_src1 + if0.alu_src2;
  assign if0.alu_new_flags = 4'b0101;
  assign if1.alu_rd_out    = if1.alu_src1 + if1.alu_src2;
  assign if1.alu_new_flags = 4'b0101;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the latency-0 instance
  always @(negedge clock) begin
    if (reset_n) begin
      chk("ready_onehot0_0", $onehot0(if0.req_ready), 1'b1);
      chk("ready_onehot0_1", $onehot0(if1.req_ready), 1'b1);
      if (if0.rsp_valid && if0.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got id=%0d data=%0h with nothing expected",
                   if0.rsp_id, if0.rsp_data);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("sb_id", if0.rsp_id, e.id);
          chk("sb_data", if0.rsp_data, e.data);
          chk("sb_flags", if0.rsp_flags, e.flags);
          pops++;
        end
      end
    end
  end

  // One op on the latency-0 instance, with latency checks.
  task automatic op0(input vec_t v);
    bit got;
    rsp_t e;
    got = 0;
    @(negedge clock);
    if0.req_valid = '0;
    if0.req_valid[v.id] = 1'b1;
    if0.req_src1[v.id*32 +: 32] = v.s1;
    if0.req_src2[v.id*32 +: 32] = v.s2;
    if0.req_ctrl_cmd[v.id*8 +: 8] = v.cmd;
    if0.flags_load = v.fl;
    if0.flags_in = v.fin;
    e.id = v.id[0];
    e.data = v.exp_data;
    e.flags = 4'b0101;
    sb.push_back(e);
    exp_cnt++;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (if0.req_ready[v.id]) got = 1;
      else @(negedge clock);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no req_ready for id %0d, required ready", v.id);
      if0.req_valid = '0;
      if0.flags_load = 1'b0;
      sb.delete();
      return;
    end
    @(posedge clock);
    #1;
    if0.req_valid = '0;
    if0.flags_load = 1'b0;
    chk("lat_edge0_rsp_valid", if0.rsp_valid, 1'b0);
    chk("lat_edge0_ready", if0.req_ready, 2'b00);
    @(posedge clock);
    #1;
    chk("lat_edge1_rsp_valid", if0.rsp_valid, 1'b1);
    @(posedge clock);
    #1;
    chk("sb_drain", sb.size(), 0);
    sb.delete();
    chk("op_count", if0.op_count, exp_cnt);
    chk("flags_reg", if0.alu_current_flags, v.exp_reg);
  endtask

  vec_t vecs[5];

  initial begin
    bit seen;
    int base;
    rsp_t e;

    vecs[0] = '{0, 32'd194, 32'd204, 8'h09, 1'b0, 4'h0, 32'd398, 4'b0101};
    vecs[1] = '{0, 32'd5, 32'd7, 8'h08, 1'b1, 4'b1000, 32'd12, 4'b1000};
    vecs[2] = '{1, 32'hFFFF_FFFF, 32'd1, 8'h08, 1'b0, 4'h0, 32'd0, 4'b1000};
    vecs[3] = '{0, 32'd100, 32'd23, 8'h01, 1'b0, 4'h0, 32'd123, 4'b0101};
    vecs[4] = '{1, 32'h8000_0000, 32'h8000_0000, 8'h3F, 1'b0, 4'h0, 32'd0, 4'b0101};

    reset_n = 1'b0;
    if0.req_valid = '0; if0.req_src1 = '0; if0.req_src2 = '0; if0.req_ctrl_cmd = '0;
    if0.rsp_ready = 1'b1; if0.flags_load = 1'b0; if0.flags_in = '0;
    if1.req_valid = '0; if1.req_src1 = '0; if1.req_src2 = '0; if1.req_ctrl_cmd = '0;
    if1.rsp_ready = 1'b1; if1.flags_load = 1'b0; if1.flags_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_if0", {if0.alu_src1, if0.alu_src2, if0.alu_ctrl_cmd, if0.alu_current_flags,
                    if0.rsp_valid, if0.rsp_id, if0.rsp_data, if0.rsp_flags, if0.op_count,
                    if0.req_ready}, '0);
    chk("rst_if1", {if1.alu_src1, if1.alu_src2, if1.alu_ctrl_cmd, if1.alu_current_flags,
                    if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.rsp_flags, if1.op_count,
                    if1.req_ready}, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven single ops
    foreach (vecs[i]) op0(vecs[i]);

    // Both requesters valid continuously: grant order 0,1,0,1
    @(negedge clock);
    if0.req_src1 = {32'd1000, 32'd10};
    if0.req_src2 = {32'd1, 32'd20};
    if0.req_ctrl_cmd = {8'h08, 8'h08};
    for (int k = 0; k < 4; k++) begin
      e.id = k[0];
      e.data = k[0] ? 32'd1001 : 32'd30;
      e.flags = 4'b0101;
      sb.push_back(e);
    end
    exp_cnt += 4;
    base = pops;
    if0.req_valid = 2'b11;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock);
      #1;
      if (pops - base >= 4) break;
    end
    if0.req_valid = '0;
    chk("rr_pops", pops - base, 4);
    @(posedge clock);
    #1;
    chk("rr_sb_drain", sb.size(), 0);
    sb.delete();
    chk("rr_op_count", if0.op_count, exp_cnt);
    chk("rr_flags_reg", if0.alu_current_flags, 4'b0101);

    // Backpressure
    @(negedge clock);
    if0.rsp_ready = 1'b0;
    if0.req_src1[31:0] = 32'd7;
    if0.req_src2[31:0] = 32'd9;
    if0.req_ctrl_cmd[7:0] = 8'h08;
    if0.req_valid = 2'b01;
    e.id = 1'b0; e.data = 32'd16; e.flags = 4'b0101;
    sb.push_back(e);
    exp_cnt++;
    @(posedge clock);
    #1;
    if0.req_valid = '0;
    @(posedge clock);
    #1;
    chk("bp_rsp_valid", if0.rsp_valid, 1'b1);
    if0.req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      chk("bp_hold_valid", if0.rsp_valid, 1'b1);
      chk("bp_hold_data", if0.rsp_data, 32'd16);
      chk("bp_hold_id", if0.rsp_id, 1'b0);
      chk("bp_hold_flags", if0.rsp_flags, 4'b0101);
      chk("bp_hold_ready", if0.req_ready, 2'b00);
      chk("bp_hold_count", if0.op_count, exp_cnt - 1);
    end
    if0.rsp_ready = 1'b1;
    if0.req_valid = '0;
    @(posedge clock);
    #1;
    chk("bp_done_valid", if0.rsp_valid, 1'b0);
    chk("bp_sb_drain", sb.size(), 0);
    sb.delete();
    chk("bp_op_count", if0.op_count, exp_cnt);

    // ALU_LATENCY=3 instance: req1 single op
    @(negedge clock);
    if1.req_src1[63:32] = 32'd300;
    if1.req_src2[63:32] = 32'd400;
    if1.req_ctrl_cmd[15:8] = 8'h09;
    if1.req_valid = 2'b10;
    #1;
    chk("l3_ready", if1.req_ready, 2'b10);
    @(posedge clock);
    #1;
    if1.req_valid = '0;
    for (int ed = 1; ed <= 4; ed++) begin
      @(posedge clock);
      #1;
      chk("l3_rsp_valid", if1.rsp_valid, ed == 4);
      chk("l3_src1", if1.alu_src1, 32'd300);
      chk("l3_src2", if1.alu_src2, 32'd400);
    end
    chk("l3_data", if1.rsp_data, 32'd700);
    chk("l3_id", if1.rsp_id, 1'b1);
    chk("l3_flags_reg", if1.alu_current_flags, 4'b0101);
    @(posedge clock);
    #1;
    chk("l3_done", if1.rsp_valid, 1'b0);
    chk("l3_op_count", if1.op_count, 16'd1);

    // Reset during EXEC: first move rr_ptr to 1 with a req0 op
    @(negedge clock);
    if1.req_src1[31:0] = 32'd1;
    if1.req_src2[31:0] = 32'd2;
    if1.req_ctrl_cmd[7:0] = 8'h08;
    if1.req_valid = 2'b01;
    @(posedge clock);
    #1;
    if1.req_valid = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clock);
      #1;
      seen = if1.rsp_valid;
    end
    chk("r6_pre_valid", seen, 1'b1);
    @(posedge clock);
    #1;
    chk("r6_pre_count", if1.op_count, 16'd2);
    @(negedge clock);
    if1.req_src1[63:32] = 32'd5;
    if1.req_src2[63:32] = 32'd6;
    if1.req_valid = 2'b10;
    @(posedge clock);
    #1;
    if1.req_valid = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("r6_rst_outputs", {if1.alu_src1, if1.alu_src2, if1.alu_ctrl_cmd, if1.alu_current_flags,
                           if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.rsp_flags, if1.op_count,
                           if1.req_ready}, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (if1.rsp_valid) seen = 1;
    end
    chk("r6_no_rsp", seen, 1'b0);
    @(negedge clock);
    if1.req_src1[31:0] = 32'd11;
    if1.req_src2[31:0] = 32'd22;
    if1.req_valid = 2'b11;
    #1;
    chk("r6_ready_from_ptr0", if1.req_ready, 2'b01);
    @(posedge clock);
    #1;
    if1.req_valid = '0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clock);
      #1;
      seen = if1.rsp_valid;
    end
    chk("r6_post_valid", seen, 1'b1);
    chk("r6_post_id", if1.rsp_id, 1'b0);
    chk("r6_post_data", if1.rsp_data, 32'd33);
    @(posedge clock);
    #1;
    chk("r6_post_count", if1.op_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
